// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Register-address width of the MIPS register file.
    localparam int REG_AW = 5;

    // Writes to r0 are discarded, so r0 never creates a load-use dependency.
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible one edge after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping, clr wins over inc.
//
// Ports: ck/rstn clock and async active-low reset, clr synchronous clear,
//        inc count enable, q current count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         ck,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enable/flush sequencer for the 5-stage core: load-use stall, redirect flush, memory freeze.
// Latency: enables/flushes are combinational (cycle N inputs act at edge N+1); state, timeout, counters registered.
// Backpressure: mem_busy freezes every stage; freeze > redirect > load-use in every state.
//
// Ports: ck/rstn clock and async active-low reset; id_rs/id_rt/id_uses_rt decode operands;
//        ex_memread/ex_regdst load in EX; ex_branch_taken/ex_jump redirect; mem_busy freeze request;
//        perf_clr counter clear; *_en register enables; *_flush bubble inserts; ctrl_state FSM state;
//        mem_timeout sticky busy-timeout flag; stall_cnt/flush_cnt/freeze_cnt performance counters.
// Build option: define HAZ_PERF_EN to keep the saturating performance counters; otherwise they read 0.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 16
) (
    input  logic              ck,
    input  logic              rstn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_regdst,
    input  logic              ex_branch_taken,
    input  logic              ex_jump,
    input  logic              mem_busy,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        ctrl_state,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    localparam logic [1:0]  FL_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    ctrl_state_t state, state_nxt;
    ctrl_state_t ret_state, ret_state_nxt;
    ctrl_state_t eval_state;
    logic [1:0]  flush_left, flush_left_nxt;
    logic [15:0] busy_cnt;

    logic redirect;
    logic lu_hit;

    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_flush_c, id_ex_flush_c;
    logic stall_ev, flush_ev, freeze_ev;

    assign redirect = ex_branch_taken | ex_jump;
    assign lu_hit   = ex_memread && (ex_regdst != REG_ZERO) &&
                      ((ex_regdst == id_rs) || (id_uses_rt && (ex_regdst == id_rt)));

    // On the FREEZE exit cycle the pipe behaves as if it were still in the
    // state it froze from, so a redirect held in EX is serviced right away.
    assign eval_state = (state == FREEZE) ? ret_state : state;

    always_comb begin
        pc_en_c        = 1'b0;
        if_id_en_c     = 1'b0;
        id_ex_en_c     = 1'b0;
        ex_mem_en_c    = 1'b0;
        mem_wb_en_c    = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        stall_ev       = 1'b0;
        flush_ev       = 1'b0;
        freeze_ev      = 1'b0;
        state_nxt      = state;
        ret_state_nxt  = ret_state;
        flush_left_nxt = flush_left;

        if (mem_busy) begin
            freeze_ev = 1'b1;
            state_nxt = FREEZE;
            if (state != FREEZE) begin
                ret_state_nxt = state;
            end
        end else begin
            case (eval_state)
                FLUSH: begin
                    // ID contents are being discarded, so load-use is irrelevant here.
                    {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = 5'b11111;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    flush_ev      = 1'b1;
                    if (redirect) begin
                        flush_left_nxt = FL_RELOAD;
                        state_nxt      = FLUSH;
                    end else begin
                        flush_left_nxt = flush_left - 2'd1;
                        state_nxt      = (flush_left == 2'd1) ? RUN : FLUSH;
                    end
                end
                default: begin
                    {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = 5'b11111;
                    state_nxt = RUN;
                    if (redirect) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        flush_ev      = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt      = FLUSH;
                            flush_left_nxt = FL_RELOAD;
                        end
                    end else if (lu_hit) begin
                        // Hold PC and IF/ID, push a bubble into EX; the bubble
                        // clears ex_memread so the stall is a single cycle.
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                        stall_ev      = 1'b1;
                    end
                end
            endcase
        end
    end

    // All strobes are forced low while reset is held.
    assign pc_en       = rstn & pc_en_c;
    assign if_id_en    = rstn & if_id_en_c;
    assign id_ex_en    = rstn & id_ex_en_c;
    assign ex_mem_en   = rstn & ex_mem_en_c;
    assign mem_wb_en   = rstn & mem_wb_en_c;
    assign if_id_flush = rstn & if_id_flush_c;
    assign id_ex_flush = rstn & id_ex_flush_c;
    assign ctrl_state  = state;

    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            ret_state  <= RUN;
            flush_left <= 2'd0;
        end else begin
            state      <= state_nxt;
            ret_state  <= ret_state_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    // Consecutive busy-cycle counter; holds at all-ones so a long stall never re-arms.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            busy_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else if (mem_busy) begin
            if (busy_cnt != 16'hFFFF) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
            if ((busy_cnt + 16'd1) == TIMEOUT_V) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            busy_cnt <= 16'd0;
        end
    end

`ifdef HAZ_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .ck   (ck),
        .rstn (rstn),
        .clr  (perf_clr),
        .inc  (stall_ev),
        .q    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .ck   (ck),
        .rstn (rstn),
        .clr  (perf_clr),
        .inc  (flush_ev),
        .q    (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .ck   (ck),
        .rstn (rstn),
        .clr  (perf_clr),
        .inc  (freeze_ev),
        .q    (freeze_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = ^{perf_clr, stall_ev, flush_ev, freeze_ev};
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign freeze_cnt  = '0;
`endif

endmodule
